// File: rtl/combination_lock_supervisor_if.sv
// Signal bundle between the combination-lock supervisor and its environment
// (buttons in, datapath strobes and status out).
interface combination_lock_supervisor_if;
  logic       Btn1;
  logic       Btn2;
  logic [1:0] lock_state;
  logic       Key1;
  logic       Key2;
  logic       LockReset;
  logic       unlocked;
  logic       lockout;
  logic [3:0] fail_count;
  logic [2:0] state;

  modport master (
    input  Btn1, Btn2, lock_state,
    output Key1, Key2, LockReset, unlocked, lockout, fail_count, state
  );

  modport slave (
    output Btn1, Btn2, lock_state,
    input  Key1, Key2, LockReset, unlocked, lockout, fail_count, state
  );
endinterface

// File: rtl/combination_lock_supervisor.sv
// Sequencing supervisor for the 4-state combination-lock datapath.
// Define LOCK_SUPERVISOR_LOCKOUT_EN to build the fail-lockout state and timer.
module combination_lock_supervisor #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int OPEN_CYCLES    = 500,
  parameter int CNT_W          = 16
) (
  input logic Clk,
  input logic Reset,
  combination_lock_supervisor_if.master lock_if
);

  typedef enum logic [2:0] {
    READY   = 3'd0,
    PULSE   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] OPEN_LOAD    = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]       FAIL_LIMIT   = 4'(MAX_FAILS);

  // Out-of-range configurations elaborate an empty marker scope.
  if (MAX_FAILS < 1 || MAX_FAILS > 15 || LOCKOUT_CYCLES < 1 || OPEN_CYCLES < 1) begin : g_bad_config
  end

  state_t           state_q, state_d;
  logic             b1_q, b2_q;
  logic             key1_q, key1_d;
  logic             key2_q, key2_d;
  logic             lock_reset_q, lock_reset_d;
  logic             unlocked_q, unlocked_d;
  logic             lockout_q, lockout_d;
  logic [3:0]       fails_q, fails_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       prev_q, prev_d;

  logic       rise1, rise2;
  logic       advanced;
  logic [3:0] fails_inc;

  assign rise1     = lock_if.Btn1 & ~b1_q;
  assign rise2     = lock_if.Btn2 & ~b2_q;
  assign advanced  = ({1'b0, lock_if.lock_state} == ({1'b0, prev_q} + 3'd1));
  assign fails_inc = (fails_q == 4'd15) ? 4'd15 : fails_q + 4'd1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= READY;
      b1_q         <= 1'b0;
      b2_q         <= 1'b0;
      key1_q       <= 1'b0;
      key2_q       <= 1'b0;
      lock_reset_q <= 1'b1;
      unlocked_q   <= 1'b0;
      lockout_q    <= 1'b0;
      fails_q      <= 4'd0;
      timer_q      <= '0;
      prev_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      b1_q         <= lock_if.Btn1;
      b2_q         <= lock_if.Btn2;
      key1_q       <= key1_d;
      key2_q       <= key2_d;
      lock_reset_q <= lock_reset_d;
      unlocked_q   <= unlocked_d;
      lockout_q    <= lockout_d;
      fails_q      <= fails_d;
      timer_q      <= timer_d;
      prev_q       <= prev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    key1_d       = 1'b0;
    key2_d       = 1'b0;
    lock_reset_d = 1'b0;
    fails_d      = fails_q;
    timer_d      = timer_q;
    prev_d       = prev_q;

    case (state_q)
      READY: begin
        // Simultaneous rises are ambiguous and therefore ignored.
        if (rise1 ^ rise2) begin
          key1_d  = rise1;
          key2_d  = rise2;
          prev_d  = lock_if.lock_state;
          state_d = PULSE;
        end
      end
      PULSE: state_d = CHECK;
      CHECK: begin
        if (advanced) begin
          if (lock_if.lock_state == 2'd3) begin
            state_d = OPEN;
            timer_d = OPEN_LOAD;
            fails_d = 4'd0;
          end else begin
            state_d = READY;
          end
        end else begin
          lock_reset_d = 1'b1;
          fails_d      = fails_inc;
          state_d      = READY;
`ifdef LOCK_SUPERVISOR_LOCKOUT_EN
          if (fails_inc >= FAIL_LIMIT) begin
            state_d = LOCKOUT;
            timer_d = LOCKOUT_LOAD;
          end
`endif
        end
      end
      OPEN: begin
        if (timer_q == '0) begin
          lock_reset_d = 1'b1;
          state_d      = READY;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
`ifdef LOCK_SUPERVISOR_LOCKOUT_EN
      LOCKOUT: begin
        if (timer_q == '0) begin
          fails_d = 4'd0;
          state_d = READY;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = READY;
    endcase

    unlocked_d = (state_d == OPEN);
`ifdef LOCK_SUPERVISOR_LOCKOUT_EN
    lockout_d  = (state_d == LOCKOUT);
`else
    lockout_d  = 1'b0;
`endif
  end

  assign lock_if.Key1       = key1_q;
  assign lock_if.Key2       = key2_q;
  assign lock_if.LockReset  = lock_reset_q;
  assign lock_if.unlocked   = unlocked_q;
`ifdef LOCK_SUPERVISOR_LOCKOUT_EN
  assign lock_if.lockout    = lockout_q;
`else
  assign lock_if.lockout    = 1'b0;
`endif
  assign lock_if.fail_count = fails_q;
  assign lock_if.state      = state_q;

`ifndef LOCK_SUPERVISOR_LOCKOUT_EN
  logic unused_lockout;
  assign unused_lockout = lockout_q ^ (^FAIL_LIMIT) ^ (^LOCKOUT_LOAD);
`endif

endmodule

// File: doc/combination_lock_supervisor.md
# combination_lock_supervisor

Sequencing controller in front of the 4-state combination-lock datapath (lock state 0→1→2→3, advanced by Key1/Key2 strobes with Password applied directly to the datapath). Converts raw button levels into single-cycle key strobes and checks after every strobe whether the lock advanced. On a failed entry it resets the lock and counts the failure; after too many failures it locks out all input for a fixed time. It auto-relocks the datapath after a fixed open time.

## Interface
- `MAX_FAILS`, default 3: failed entries before lockout (1–15).
- `LOCKOUT_CYCLES`, default 1000: lockout duration in clocks (≥1, < 2^CNT_W).
- `OPEN_CYCLES`, default 500: unlocked duration in clocks (≥1, < 2^CNT_W).
- `CNT_W`, default 16: timer width.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `Clk` input 1: rising-edge clock.
- `Reset` input 1: asynchronous, active-low reset.
- `Btn1` input 1: button 1 level, already synchronous to `Clk`.
- `Btn2` input 1: button 2 level, already synchronous to `Clk`.
- `lock_state` input 2: datapath state (3 = open).
- `Key1` output 1: one-cycle strobe to datapath Key1.
- `Key2` output 1: one-cycle strobe to datapath Key2.
- `LockReset` output 1: active-high synchronous reset to datapath.
- `unlocked` output 1: high in OPEN.
- `lockout` output 1: high in LOCKOUT.
- `fail_count` output 4: failures since last clear.
- `state` output 3: supervisor state encoding.

## Operation
- States: READY=0, PULSE=1, CHECK=2, OPEN=3, LOCKOUT=4. Encodings 5–7 → READY.
- Edge detect: `b1_q`/`b2_q` register Btn levels every cycle in all states. A rise is `Btn & ~b_q`.
- READY:
  - Exactly one rise → register strobe (`Key1` or `Key2`) high next cycle; capture `prev = lock_state`; go to PULSE.
  - Both rise in the same cycle → ignored, no strobe, no fail.
- PULSE: strobe high this cycle; clear strobe; go to CHECK.
- CHECK: sample `lock_state`.
  - `lock_state == prev+1` and `== 3` → OPEN; load open timer; clear `fail_count`.
  - `lock_state == prev+1` and `< 3` → READY.
  - Otherwise (unchanged or regressed) → fail: `LockReset` high next cycle for one cycle; increment `fail_count` (saturate at 15).
    - If the new count reaches `MAX_FAILS` → LOCKOUT; load lockout timer.
    - Otherwise → READY.
- OPEN: `unlocked`=1; button rises ignored; timer decrements. At 0: `LockReset` one-cycle pulse; go to READY.
- LOCKOUT: `lockout`=1; button rises ignored; timer decrements. At 0: clear `fail_count`; go to READY.
- Button rises outside READY are dropped, not queued. A button held across a return to READY does not retrigger.

## Timing
- Reset values:
  - `state`=READY.
  - `Key1`=`Key2`=0.
  - `LockReset`=1, cleared at the first `Clk` edge after release.
  - `unlocked`=`lockout`=0, `fail_count`=0, timers=0, `b1_q`=`b2_q`=0.
- All outputs are registered.
- Rise at cycle n: strobe high in cycle n+1; `lock_state` judged in cycle n+2; READY again, or `LockReset`/`unlocked`/`lockout` asserted, in cycle n+3.
- Minimum spacing between accepted entries: 3 cycles.
- Timers load N−1 on entry. OPEN lasts exactly `OPEN_CYCLES` cycles; LOCKOUT lasts exactly `LOCKOUT_CYCLES` cycles.
- `LockReset` pulse for a fail coincides with the first READY or LOCKOUT cycle. The relock pulse coincides with the first READY cycle.
- `Reset` asserted mid-operation returns immediately to reset values. An in-flight strobe is aborted.

## Configuration
- `LOCK_SUPERVISOR_LOCKOUT_EN` defined: full behaviour above.
- Undefined: LOCKOUT state, lockout timer and `MAX_FAILS` check are not compiled. Fails always return to READY. `fail_count` still counts and saturates at 15, and is cleared only on OPEN entry. `lockout` is tied to 0.

## Test plan
- Bench parameters: `MAX_FAILS`=3, `LOCKOUT_CYCLES`=8, `OPEN_CYCLES`=4.
- Reset release → `LockReset`=1 for the first cycle then 0, all other outputs 0, `state`=0.
- Correct entry: Password 13 + Btn1, then 7 + Btn2, then 9 + Btn1 → exactly 3 one-cycle strobes; `unlocked`=1 for 4 cycles; then `LockReset` pulse; `state`=0; `fail_count`=0.
- Wrong Password on the first Btn1 (datapath stays 0) → `LockReset` pulse in cycle n+3, `fail_count`=1.
- Three consecutive fails → `lockout`=1 for exactly 8 cycles with Btn presses producing no strobes; then `fail_count`=0 and READY.
- Btn1 and Btn2 rising in the same cycle, and Btn1 held high for 20 cycles → no strobe and exactly one strobe, respectively.
- `Reset` asserted in PULSE with `Key1`=1 → `Key1`=0 immediately; all reset values restored.
